norm_32: RTL

- Pipelined 32-bit normaliser that sits directly upstream of the team's 32-bit barrel shifter datapath.
- It takes a raw word and computes its leading-zero count, which is the left-shift amount.
- It returns the left-justified word, the shift amount and a zero flag, using valid/ready handshakes on both sides.
- Throughput is one word per cycle; latency is 2 cycles.

---
 rtl/norm_pkg.sv | 22 ++
 rtl/lzc_32.sv | 43 ++++
 rtl/norm_32.sv | 113 +++++++++++
 3 files changed

// File: rtl/norm_pkg.sv
// norm_pkg: constants and types shared by the 32-bit normaliser blocks.
//   WIDTH   - data word width (32 only)
//   CW      - width of the leading-zero count (must hold 32)
//   TAGW    - width of the opaque sideband tag
//   LZ_ZERO - count reported for an all-zero word
//   result_t - registered output bundle {data, lz, zero, tag}
package norm_pkg;

  localparam int WIDTH = 32;
  localparam int CW    = 6;
  localparam int TAGW  = 4;

  localparam logic [CW-1:0] LZ_ZERO = 6'd32;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    lz;
    logic             zero;
    logic [TAGW-1:0]  tag;
  } result_t;

endpackage

// File: rtl/lzc_32.sv
// lzc_32: purely combinational 32-bit leading-zero counter.
//   word  - input word
//   count - number of consecutive zero bits starting at bit 31 (0..32)
// Built as a tree: sixteen 2-bit priority encoders feed four merge levels,
// each merge node picking the left (more significant) child when it holds a
// one, otherwise the right child's count plus the left child's span.
module lzc_32
  import norm_pkg::*;
(
  input  logic [31:0] word,
  output logic [5:0]  count
);

  function automatic logic [5:0] lzc_tree(input logic [31:0] w);
    // Node index 0 is always the most significant group at each level.
    logic [4:0] cnt [5][16];
    logic       vld [5][16];
    for (int l = 0; l < 5; l++) begin
      for (int n = 0; n < 16; n++) begin
        cnt[l][n] = '0;
        vld[l][n] = 1'b0;
      end
    end
    // Leaf 2-bit encoders: count is 0 if the high bit is set, else 1.
    for (int n = 0; n < 16; n++) begin
      vld[0][n] = w[31-2*n] | w[30-2*n];
      cnt[0][n] = {4'b0000, ~w[31-2*n]};
    end
    // At level l the left child spans 2**l bits, so falling through to the
    // right child adds exactly bit l to its count.
    for (int l = 1; l < 5; l++) begin
      for (int n = 0; n < (16 >> l); n++) begin
        vld[l][n] = vld[l-1][2*n] | vld[l-1][2*n+1];
        cnt[l][n] = vld[l-1][2*n] ? cnt[l-1][2*n]
                                  : (cnt[l-1][2*n+1] | (5'd1 << l));
      end
    end
    return vld[4][0] ? {1'b0, cnt[4][0]} : LZ_ZERO;
  endfunction

  assign count = lzc_tree(word);

endmodule

// File: rtl/norm_32.sv
// norm_32: two-stage pipelined 32-bit normaliser feeding a barrel shifter.
//   clk, rst   - clock and asynchronous active-high reset
//   in_valid / in_ready / data_in / tag_in          - input handshake + word
//   out_valid / out_ready                           - output handshake
//   data_out   - data_in shifted left by lz_out, zero-filled
//   lz_out     - leading-zero count 0..32
//   sh_out     - lz_out[4:0], a direct shift-amount for the barrel shifter
//   zero_out   - data_in was all zeros
//   tag_out    - tag_in of the same word
// Stage 1 captures the word, tag and leading-zero count; stage 2 captures the
// left-justified result and drives the output ports directly.
module norm_32
  import norm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [TAGW-1:0]  tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    lz_out,
  output logic [4:0]       sh_out,
  output logic             zero_out,
  output logic [TAGW-1:0]  tag_out
);

  logic             s1_v;
  logic [WIDTH-1:0] s1_data;
  logic [TAGW-1:0]  s1_tag;
  logic [CW-1:0]    s1_lz;

  logic             s2_v;
  result_t          s2;
  result_t          s2_next;

  logic [CW-1:0]    lz_in;
  logic             in_transfer;
  logic             s2_load;

  lzc_32 u_lzc (
    .word  (data_in),
    .count (lz_in)
  );

  // Handshake control. in_ready depends on out_ready only through s2_load;
  // it never looks at in_valid. It is held low while rst is asserted.
  assign s2_load     = s1_v && (!s2_v || out_ready);
  assign in_ready    = !rst && (!s1_v || s2_load);
  assign in_transfer = in_valid && in_ready;

  // Five-stage logarithmic left shifter, stage gi shifting by 2**gi when
  // bit gi of the count is set. A count of 32 leaves bits [4:0] clear, and
  // the word is zero in that case anyway.
  logic [WIDTH-1:0] stage [6];
  assign stage[0] = s1_data;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_shift
      assign stage[gi+1] = s1_lz[gi] ? (stage[gi] << (1 << gi)) : stage[gi];
    end
  endgenerate

  always_comb begin
    s2_next      = s2;
    s2_next.zero = (s1_lz == LZ_ZERO);
    s2_next.data = s2_next.zero ? '0 : stage[5];
    s2_next.lz   = s1_lz;
    s2_next.tag  = s1_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_tag  <= '0;
      s1_lz   <= '0;
      s2_v    <= 1'b0;
      s2      <= '0;
    end else begin
      // Stage 1: an incoming word may overwrite a word draining this edge.
      if (in_transfer) begin
        s1_v    <= 1'b1;
        s1_data <= data_in;
        s1_tag  <= tag_in;
        s1_lz   <= lz_in;
      end else if (s2_load) begin
        s1_v    <= 1'b0;
      end

      // Stage 2: holds while stalled, reloads when downstream takes it.
      if (s2_load) begin
        s2_v <= 1'b1;
        s2   <= s2_next;
      end else if (s2_v && out_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

  assign out_valid = s2_v;
  assign data_out  = s2.data;
  assign lz_out    = s2.lz;
  assign sh_out    = s2.zero ? 5'd0 : s2.lz[4:0];
  assign zero_out  = s2.zero;
  assign tag_out   = s2.tag;

endmodule
